// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared widths, register-count derivation and sequencer state
//            encoding for the regfile_resp register-file responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    // Default data word width and register address width.
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 3;

    // Number of registers is always the full address space and is derived
    // from the address width, so every address decodes to a real entry.
    function automatic int regfile_nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Sequencer states: CLEAR zeroes storage one entry per edge, RUN serves
    // traffic until the next reset.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_clear_seq.sv
// ============================================================================
// Module   : regfile_clear_seq
// Purpose  : Post-reset clear sequencer for regfile_resp. Walks a counter
//            over every register address, asserting a clear write-enable,
//            then enters RUN and raises o_ready until the next reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_ready,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    // Last address visited by the clear walk; reaching it ends CLEAR.
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(regfile_nregs(ADDR_W) - 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;

    // State and clear-counter registers; reset restarts the walk at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: CLEAR advances one entry per edge and leaves at the
    // edge that clears the final entry; RUN is absorbing.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            CLEAR: begin
                // Counter wraps back to 0 on the exit edge, which is harmless
                // because RUN never looks at it.
                w_cnt_next = r_cnt + c_addr_one;
                if (r_cnt == c_last_addr) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_state_next = RUN;
            end
            default: begin
                w_state_next = CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Output decode: storage is cleared only in CLEAR, traffic only in RUN.
    always_comb begin
        o_ready    = 1'b0;
        o_clr_we   = 1'b0;
        o_clr_addr = r_cnt;
        case (r_state)
            CLEAR:   o_clr_we = 1'b1;
            RUN:     o_ready  = 1'b1;
            default: o_clr_we = 1'b1;
        endcase
    end

endmodule : regfile_clear_seq

`default_nettype wire

// File: rtl/regfile_resp.sv
// ============================================================================
// Module   : regfile_resp
// Purpose  : Sequenced NREGS x DATA_W register file. Self-clears after reset,
//            then accepts one write and one registered dual read per cycle,
//            qualifying each read result with RD_VALID.
// Config   : define REGFILE_BYPASS_EN to forward same-edge write data onto a
//            read port whose address matches DR; otherwise such a read
//            returns the pre-write contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_resp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] D_IN,
    input  logic              RD_EN,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    output logic [DATA_W-1:0] DATA_A,
    output logic [DATA_W-1:0] DATA_B,
    output logic              RD_VALID,
    output logic              READY
);

    localparam int c_nregs = regfile_nregs(ADDR_W);

    logic              w_ready;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    logic              w_wr_en;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    logic [DATA_W-1:0] r_mem [0:c_nregs-1];
    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic              r_rd_valid;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (CLK),
        .rst        (RST),
        .o_ready    (w_ready),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Traffic is only honoured once the clear walk has finished.
    assign w_wr_en = LD & w_ready;
    assign w_rd_en = RD_EN & w_ready;

    // Read-port source selection, including optional same-edge forwarding.
    always_comb begin
        w_rd_a = r_mem[SA];
        w_rd_b = r_mem[SB];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (DR == SA)) begin
            w_rd_a = D_IN;
        end
        if (w_wr_en && (DR == SB)) begin
            w_rd_b = D_IN;
        end
`endif
    end

    // Storage: the clear walk owns the array during CLEAR, the write port
    // during RUN. Reset itself does not touch storage; the walk that follows
    // it zeroes every entry.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (w_clr_we) begin
                r_mem[w_clr_addr] <= '0;
            end else if (w_wr_en) begin
                r_mem[DR] <= D_IN;
            end
        end
    end

    // Registered read results; data holds when no read is issued so the last
    // result stays observable after RD_VALID drops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_data_a <= w_rd_a;
                r_data_b <= w_rd_b;
            end
        end
    end

    assign DATA_A   = r_data_a;
    assign DATA_B   = r_data_b;
    assign RD_VALID = r_rd_valid;
    assign READY    = w_ready;

endmodule : regfile_resp

`default_nettype wire

// File: tb/tb_regfile_resp.sv
// ============================================================================
// Module   : tb_regfile_resp
// Purpose  : Self-checking bench for regfile_resp. A reference model computes
//            the expected outputs after every clock edge and queues them; a
//            negedge monitor pops and compares against the DUT.
// Config   : honours REGFILE_BYPASS_EN the same way the DUT does.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_resp;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int NR = 8;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST, LD, RD_EN;
    logic [AW-1:0] DR, SA, SB;
    logic [DW-1:0] D_IN;
    logic [DW-1:0] DATA_A, DATA_B;
    logic          RD_VALID, READY;

    regfile_resp dut (
        .CLK      (CLK),
        .RST      (RST),
        .LD       (LD),
        .DR       (DR),
        .D_IN     (D_IN),
        .RD_EN    (RD_EN),
        .SA       (SA),
        .SB       (SB),
        .DATA_A   (DATA_A),
        .DATA_B   (DATA_B),
        .RD_VALID (RD_VALID),
        .READY    (READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        logic          valid;
        logic          ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    logic [DW-1:0] m_mem [NR];
    int            m_clr_left = NR;
    logic [DW-1:0] m_da = '0, m_db = '0;
    logic          m_valid = 1'b0, m_ready = 1'b0;

    // Effect of one clock edge given the inputs currently applied.
    function automatic void model_edge();
        logic [DW-1:0] a, b;
        if (RST) begin
            m_clr_left = NR;
            m_da = '0; m_db = '0; m_valid = 1'b0; m_ready = 1'b0;
        end else if (m_clr_left > 0) begin
            m_mem[NR - m_clr_left] = '0;
            m_clr_left = m_clr_left - 1;
            m_valid = 1'b0;
            m_ready = (m_clr_left == 0);
        end else begin
            if (RD_EN) begin
                a = m_mem[SA];
                b = m_mem[SB];
                if (BYP && LD && DR == SA) a = D_IN;
                if (BYP && LD && DR == SB) b = D_IN;
                m_da = a;
                m_db = b;
            end
            m_valid = RD_EN;
            if (LD) m_mem[DR] = D_IN;
        end
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs, advance one edge, queue the model's post-edge outputs.
    task automatic cyc(input logic rst_i, input logic ld_i, input logic [AW-1:0] dr_i,
                       input logic [DW-1:0] din_i, input logic rd_i,
                       input logic [AW-1:0] sa_i, input logic [AW-1:0] sb_i);
        exp_t e;
        RST = rst_i; LD = ld_i; DR = dr_i; D_IN = din_i;
        RD_EN = rd_i; SA = sa_i; SB = sb_i;
        model_edge();
        e.da = m_da; e.db = m_db; e.valid = m_valid; e.ready = m_ready;
        @(posedge CLK);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, a, b);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0, '0, '0);
    endtask

    // Scoreboard monitor: compares every queued expectation at the negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (DATA_A !== e.da || DATA_B !== e.db || RD_VALID !== e.valid || READY !== e.ready) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got A=%h B=%h V=%b R=%b expected A=%h B=%h V=%b R=%b",
                             $time, DATA_A, DATA_B, RD_VALID, READY, e.da, e.db, e.valid, e.ready);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] xa;
        RST = 1'b1; LD = 1'b0; RD_EN = 1'b0; DR = '0; SA = '0; SB = '0; D_IN = '0;
        for (int i = 0; i < NR; i++) m_mem[i] = $urandom;

        // Reset state
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("reset_ready", {31'b0, READY}, 32'd0);
        chk("reset_data_a", DATA_A, 32'd0);

        // Clear walk: READY low through edge 7, high after edge 8
        for (int k = 1; k <= NR; k++) begin
            idle();
            chk($sformatf("clear_ready_e%0d", k), {31'b0, READY}, (k == NR) ? 32'd1 : 32'd0);
        end

        // Every entry reads back zero
        for (int i = 0; i < NR; i++) rd(AW'(i), AW'(NR - 1 - i));

        // Write then read
        wr(3'd0, 32'd123);
        rd(3'd0, 3'd1);
        chk("wr_rd_a", DATA_A, 32'd123);
        chk("wr_rd_b", DATA_B, 32'd0);
        chk("wr_rd_valid", {31'b0, RD_VALID}, 32'd1);

        // Same-edge write/read of the same address
        cyc(1'b0, 1'b1, 3'd2, 32'hDEADBEEF, 1'b1, 3'd2, 3'd2);
        chk("same_edge_a", DATA_A, BYP ? 32'hDEADBEEF : 32'd0);
        chk("same_edge_b", DATA_B, BYP ? 32'hDEADBEEF : 32'd0);
        rd(3'd2, 3'd2);
        chk("after_write_a", DATA_A, 32'hDEADBEEF);

        // Hold: read r0 then drop RD_EN with unknown addresses for 3 cycles
        rd(3'd0, 3'd0);
        xa = 'x;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0, xa, xa);
        chk("hold_valid", {31'b0, RD_VALID}, 32'd0);
        chk("hold_data_a", DATA_A, 32'd123);

        // Mid-RUN reset, traffic ignored during the re-clear
        wr(3'd3, 32'd55);
        rd(3'd3, 3'd3);
        cyc(1'b1, 1'b0, '0, '0, 1'b1, 3'd3, 3'd3);
        chk("midrun_rst_a", DATA_A, 32'd0);
        chk("midrun_rst_ready", {31'b0, READY}, 32'd0);
        for (int k = 0; k < NR; k++) cyc(1'b0, 1'b1, 3'd5, 32'd77, 1'b1, 3'd5, 3'd3);
        chk("clear_ignores_rd", {31'b0, RD_VALID}, 32'd0);
        rd(3'd3, 3'd5);
        chk("reclear_r3", DATA_A, 32'd0);
        chk("clear_ignores_wr_r5", DATA_B, 32'd0);

        // Reset in the middle of CLEAR restarts the walk
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) idle();
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int k = 0; k < NR; k++) idle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 149) == 0), $urandom_range(0, 1), AW'($urandom), $urandom,
                ($urandom_range(0, 3) != 0), AW'($urandom), AW'($urandom));
        end

        idle();
        idle();
        @(negedge CLK);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_resp

`default_nettype wire
